// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, framing/parity strobes.
//            Define UART_RX_PARITY_EN for 8E1 frames (even parity bit).
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       new_byte,
  output logic [7:0] the_byte,
  output logic       framing_err,
  output logic       parity_err
);

  localparam logic [15:0] c_full_tc = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_half_tc = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_rx_meta, r_rx_s;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [15:0] r_timer, w_timer_next;
  logic [2:0]  r_index, w_index_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_new_byte, w_new_byte_next;
  logic        r_framing_err, w_framing_err_next;
  logic        w_full, w_half;

  assign w_full = (r_timer == c_full_tc);
  assign w_half = (r_timer == c_half_tc);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, w_par_bit_next;
  logic r_parity_err, w_parity_err_next;
`endif

  // r_armed blocks IDLE until rx_s has been genuinely high since reset, so a
  // frame already in flight at reset release is not picked up mid-way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_sync_vld    <= 2'b00;
      r_armed       <= 1'b0;
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_index       <= '0;
      r_shift       <= '0;
      r_byte        <= 8'h00;
      r_new_byte    <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_rx_meta     <= rx;
      r_rx_s        <= r_rx_meta;
      r_sync_vld    <= {r_sync_vld[0], 1'b1};
      r_armed       <= r_armed | (r_sync_vld[1] & r_rx_s);
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_index       <= w_index_next;
      r_shift       <= w_shift_next;
      r_byte        <= w_byte_next;
      r_new_byte    <= w_new_byte_next;
      r_framing_err <= w_framing_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bit    <= w_par_bit_next;
      r_parity_err <= w_parity_err_next;
    end
  end
`endif

  always_comb begin
    w_state_next       = r_state;
    w_timer_next       = r_timer + 16'd1;
    w_index_next       = r_index;
    w_shift_next       = r_shift;
    w_byte_next        = r_byte;
    w_new_byte_next    = 1'b0;
    w_framing_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_next     = r_par_bit;
    w_parity_err_next  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        if (r_armed && !r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_half) begin
          w_timer_next = '0;
          w_index_next = '0;
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_timer_next          = '0;
          w_shift_next[r_index] = r_rx_s;
          w_index_next          = r_index + 3'd1;
          if (r_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_timer_next   = '0;
          w_par_bit_next = r_rx_s;
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_timer_next = '0;
          if (!r_rx_s) begin
            w_framing_err_next = 1'b1;
            w_state_next       = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (^{r_shift, r_par_bit}) begin
            w_parity_err_next = 1'b1;
            w_state_next      = S_IDLE;
`endif
          end else begin
            w_byte_next     = r_shift;
            w_new_byte_next = 1'b1;
            w_state_next    = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        w_timer_next = '0;
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: begin
        w_timer_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign new_byte    = r_new_byte;
  assign the_byte    = r_byte;
  assign framing_err = r_framing_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high, 8N1 LSB first.
REQ-005 SHALL have port: new_byte  output  1  one-cycle strobe, valid byte on the_byte; feeds buffer_comparator.new_byte.
REQ-006 SHALL have port: the_byte  output  8  last correctly received byte; feeds buffer_comparator.the_byte.
REQ-007 SHALL have port: framing_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-008 SHALL have port: parity_err  output  1  one-cycle strobe, parity mismatch (see Configuration).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK (plus PARITY per REQ-021), with one 16-bit bit-timer and one 3-bit bit-index.
REQ-011 IDLE: rx_s==0 -> START, timer cleared.
REQ-012 START: after CLKS_PER_BIT/2 (integer floor) cycles, resample rx_s; 0 -> DATA, timer cleared, index 0; 1 -> IDLE (glitch rejected, no strobe).
REQ-013 DATA: every CLKS_PER_BIT cycles sample rx_s into shift register bit [index], LSB first; after index 7 -> STOP.
REQ-014 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> load the_byte, pulse new_byte, go IDLE; 0 -> pulse framing_err, the_byte unchanged, no new_byte, go BREAK.
REQ-015 BREAK: remain until rx_s==1, then IDLE; no strobes while in BREAK.
REQ-016 new_byte, framing_err and parity_err SHALL be registered, high exactly one cycle, the cycle after the stop-bit sample; mutually exclusive.
REQ-017 the_byte SHALL update in the same cycle new_byte rises and hold until next valid frame.
REQ-018 Return to IDLE at mid-stop-bit SHALL allow back-to-back frames with zero idle time; no frame lost at any CLKS_PER_BIT.
REQ-019 Timer SHALL never wrap within a bit; comparisons use CLKS_PER_BIT-1 terminal count.

Reset
REQ-020 rst_n low at a rising edge SHALL force: state IDLE, timer 0, index 0, shift register 0, synchronizer 1,1, the_byte 8'h00, new_byte 0, framing_err 0, parity_err 0; mid-frame reset aborts frame with no strobe; after release a frame already in progress is ignored until rx_s returns high then falls (IDLE edge).

Configuration
REQ-021 Macro UART_RX_PARITY_EN defined: PARITY state inserted between DATA and STOP, one extra bit sampled after CLKS_PER_BIT; even parity over 8 data bits; mismatch -> pulse parity_err at stop-bit decision, no new_byte, the_byte unchanged; framing error takes priority over parity error.
REQ-022 Macro UART_RX_PARITY_EN undefined: frame is 8N1, no PARITY state, parity_err tied 0.

Verification
REQ-023 CLKS_PER_BIT=8, send 0x4D ("M") 8N1 -> new_byte one cycle, the_byte=0x4D, no errors.
REQ-024 Send "MARCO" back-to-back, no idle gap, into buffer_comparator -> five new_byte strobes, bytes 4D 41 52 43 4F, match high once.
REQ-025 Send 0x55 with stop bit low, then rx held low 3 bit-times -> framing_err one pulse, no new_byte, the_byte unchanged; then 0x41 -> the_byte=0x41.
REQ-026 rx low pulse of 3 cycles (< CLKS_PER_BIT/2) -> no strobes, state back to IDLE; rst_n low mid DATA of 0xA5 -> no strobe, the_byte=0x00.
REQ-027 With UART_RX_PARITY_EN: 0x03 with parity 0 -> new_byte, the_byte=0x03; 0x07 with parity 0 -> parity_err pulse, no new_byte.
